alu_result_buffer: RTL and testbench

//  Downstream stage of the FSM/ALU controller. Captures each ALU transaction {a,b,op,res,CF,GZ}

---
 rtl/alu_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/alu_result_buffer.sv | 100 ++++++++++
 tb/tb_alu_result_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller datapath and its result buffer:
// opcode encodings, the default datapath width and the layout of a logged record.
package alu_pkg;

    // Default operand/result width of the ALU datapath
    localparam int ALU_DW = 7;

    // Opcode encodings carried on in_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Field offsets inside a logged record {mis, op, cf, gz, res}
    localparam int REC_RES_LSB = 0;
    localparam int REC_GZ      = ALU_DW;
    localparam int REC_CF      = ALU_DW + 1;
    localparam int REC_OP      = ALU_DW + 2;
    localparam int REC_MIS     = ALU_DW + 3;
    localparam int REC_W       = ALU_DW + 4;

    // Record view for consumers working at the default width
    typedef struct packed {
        logic              mis;
        logic              op;
        logic              cf;
        logic              gz;
        logic [ALU_DW-1:0] res;
    } alu_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy tracking. Pointers wrap naturally
// (DEPTH is a power of two); full/empty are decoded from the level register.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop needs data; a push into a full FIFO is only legal when a pop frees a slot
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // Head entry; forced to zero when nothing is held so the port is clean after reset
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage write; data needs no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy control
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Result buffer behind the FSM/ALU controller: checks each strobed ALU
// transaction against a reference model, tags it, queues it for a consumer
// and keeps saturating counts of mismatches and overflow drops.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DW    = ALU_DW,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_a,
    input  logic [DW-1:0]            in_b,
    input  logic                     in_op,
    input  logic [DW-1:0]            in_res,
    input  logic                     in_cf,
    input  logic                     in_gz,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW+3:0]            out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [CW-1:0]            err_cnt,
    output logic [CW-1:0]            drop_cnt
);

    localparam int RW = DW + 4;

    logic [DW-1:0] exp_res_p0;
    logic          exp_cf_p0;
    logic          exp_gz_p0;
    logic          mis_p0;
    logic [RW-1:0] rec_p0;
    logic          push;
    logic          pop;
    logic          drop;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        logic [CW-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (&c) ? c : c + one;
    endfunction

    // Stage p0: reference model of the ALU and mismatch tag
    always_comb begin
        exp_res_p0 = '0;
        exp_cf_p0  = 1'b0;
        if (in_op == OP_SUB) begin
            exp_res_p0 = in_a - in_b;
            exp_cf_p0  = (in_a < in_b);
        end else begin
            {exp_cf_p0, exp_res_p0} = {1'b0, in_a} + {1'b0, in_b};
        end
        exp_gz_p0 = (exp_res_p0 != '0);
        mis_p0    = (in_res != exp_res_p0) || (in_cf != exp_cf_p0) || (in_gz != exp_gz_p0);
        rec_p0    = {mis_p0, in_op, in_cf, in_gz, in_res};
    end

    // Handshake: a pop in the same cycle makes room for a push even when full
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (rec_p0),
        .rdata (out_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Saturating mismatch and drop statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (in_valid && mis_p0) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: main instance (CW=8) plus a CW=2
// instance sharing the same stimulus for the saturation case.
module tb_alu_result_buffer;

    localparam int DW = 7;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_op;
    logic [DW-1:0] in_res;
    logic          in_cf;
    logic          in_gz;
    logic          out_ready;

    logic          out_valid;
    logic [DW+3:0] out_data;
    logic [2:0]    level;
    logic          full;
    logic          empty;
    logic [7:0]    err_cnt;
    logic [7:0]    drop_cnt;

    logic          s_out_valid;
    logic [DW+3:0] s_out_data;
    logic [2:0]    s_level;
    logic          s_full;
    logic          s_empty;
    logic [1:0]    s_err_cnt;
    logic [1:0]    s_drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_res(in_res), .in_cf(in_cf), .in_gz(in_gz),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .full(full), .empty(empty),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    alu_result_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_res(in_res), .in_cf(in_cf), .in_gz(in_gz),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .level(s_level), .full(s_full), .empty(s_empty),
        .err_cnt(s_err_cnt), .drop_cnt(s_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int a, input int b, input logic op,
                          input int res, input logic cf, input logic gz);
        in_valid = 1'b1;
        in_a     = a[DW-1:0];
        in_b     = b[DW-1:0];
        in_op    = op;
        in_res   = res[DW-1:0];
        in_cf    = cf;
        in_gz    = gz;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
        in_res = '0; in_cf = 1'b0; in_gz = 1'b0; out_ready = 1'b0;
        #2;
        tick(); tick();
        rst = 1'b0;

        // 1: traffic then a one-cycle reset with in_valid asserted
        strobe(5, 3, 1'b0, 8, 1'b0, 1'b1);
        strobe(1, 1, 1'b0, 0, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd2);
        rst = 1'b1;
        strobe(1, 1, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);

        // 2: correct add, consumer stalled
        strobe(5, 3, 1'b0, 8, 1'b0, 1'b1);
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_data", 32'(out_data), 32'h088);
        check("add_level", 32'(level), 32'd1);
        check("add_err", 32'(err_cnt), 32'd0);
        tick();
        check("add_hold_data", 32'(out_data), 32'h088);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add_pop_empty", 32'(empty), 32'd1);

        // 3: subtract with borrow, correct then wrong carry flag
        strobe(3, 5, 1'b1, 126, 1'b1, 1'b1);
        check("sub_ok_data", 32'(out_data), 32'h3FE);
        check("sub_ok_err", 32'(err_cnt), 32'd0);
        strobe(3, 5, 1'b1, 126, 1'b0, 1'b1);
        check("sub_bad_err", 32'(err_cnt), 32'd1);
        check("sub_bad_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        tick();
        check("sub_bad_data", 32'(out_data), 32'h6FE);
        tick();
        out_ready = 1'b0;
        check("sub_drain_empty", 32'(empty), 32'd1);

        // zero result: gz must be 0; also a pop attempt while empty
        strobe(9, 9, 1'b1, 0, 1'b0, 1'b0);
        check("zero_data", 32'(out_data), 32'h200);
        check("zero_err", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("empty_pop_level", 32'(level), 32'd0);
        check("empty_pop_valid", 32'(out_valid), 32'd0);

        // 4: overflow with six correct strobes into a stalled FIFO
        for (int k = 1; k <= 6; k++) begin
            strobe(k, 1, 1'b0, k + 1, 1'b0, 1'b1);
            if (k == 4) begin
                check("ovf_full4", 32'(full), 32'd1);
                check("ovf_drop4", 32'(drop_cnt), 32'd0);
            end
        end
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        check("ovf_err", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain%0d", i), 32'(out_data), 32'h082 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drain_empty", 32'(empty), 32'd1);

        // 5: full with simultaneous pop and push (add with carry-out)
        for (int k = 1; k <= 4; k++) begin
            strobe(k, 1, 1'b0, k + 1, 1'b0, 1'b1);
        end
        check("sim_full", 32'(full), 32'd1);
        out_ready = 1'b1;
        strobe(100, 50, 1'b0, 22, 1'b1, 1'b1);
        check("sim_level", 32'(level), 32'd4);
        check("sim_drop", 32'(drop_cnt), 32'd2);
        check("sim_full_after", 32'(full), 32'd1);
        check("sim_err", 32'(err_cnt), 32'd1);
        check("sim_head1", 32'(out_data), 32'h083);
        tick();
        check("sim_head2", 32'(out_data), 32'h084);
        tick();
        check("sim_head3", 32'(out_data), 32'h085);
        tick();
        check("sim_last", 32'(out_data), 32'h196);
        tick();
        out_ready = 1'b0;
        check("sim_empty", 32'(empty), 32'd1);

        // 6: saturation of err_cnt on the CW=2 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_err", 32'(s_err_cnt), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            strobe(1, 1, 1'b0, 0, 1'b0, 1'b1);
            if (k == 3) check("sat_err3", 32'(s_err_cnt), 32'd3);
        end
        check("sat_err5", 32'(s_err_cnt), 32'd3);
        check("sat_main_err", 32'(err_cnt), 32'd5);
        check("sat_main_drop", 32'(drop_cnt), 32'd1);
        check("sat_s_drop", 32'(s_drop_cnt), 32'd1);
        tick();
        check("sat_hold", 32'(s_err_cnt), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_clear", 32'(s_err_cnt), 32'd0);
        check("sat_clear_lvl", 32'(s_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
